// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   entry_state_t : lifecycle of one fetch-queue slot (EMPTY -> PENDING -> FILLED)
//   fetch_entry_t : one queue slot {state, pc, inst}
//   PC_STEP       : byte distance between consecutive instruction words
//   wrap_idx      : circular index helper for the queue scan
package fetch_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        FILLED  = 2'd2
    } entry_state_t;

    typedef struct packed {
        entry_state_t state;
        logic [31:0]  pc;
        logic [31:0]  inst;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // (base + off) modulo depth, valid for base < depth and off < depth.
    function automatic int wrap_idx(input int base, input int off, input int depth);
        int sum;
        sum = base + off;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetch entries between instruction memory and ID.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   alloc, alloc_pc         : append a PENDING entry at tail with its PC
//   fill, fill_data         : write a returned word into the oldest PENDING entry
//   deq                     : retire the head entry (caller guarantees it is FILLED)
//   flush                   : empty the whole queue (wins over everything else)
//   count, pending          : occupied entries, entries still awaiting data
//   head_filled/pc/inst     : head entry view toward ID
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc,
    input  logic [31:0]      alloc_pc,
    input  logic             fill,
    input  logic [31:0]      fill_data,
    input  logic             deq,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] pending,
    output logic             head_filled,
    output logic [31:0]      head_pc,
    output logic [31:0]      head_inst
);

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill_idx;
    logic             fill_hit;

    // Find the oldest PENDING entry (scan from head) and count PENDING entries.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        fill_idx = '0;
        fill_hit = 1'b0;
        pending  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].state == PENDING) pending = pending + CNT_W'(1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            int j;
            j = wrap_idx(int'(head), i, DEPTH);
            if (!fill_hit && entries[j].state == PENDING) begin
                fill_hit = 1'b1;
                fill_idx = PTR_W'(j);
            end
        end
    end

    // NOTE: the entry array is a handful of flops, not a RAM, so it is reset
    // outright; clearing the payload keeps inst/inst_pc deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '{state: EMPTY, pc: 32'h0, inst: 32'h0};
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].state <= EMPTY;
            end
        end else begin
            // Fill targets a PENDING slot, alloc an EMPTY one, deq a FILLED one,
            // so the three updates never touch the same entry.
            if (fill && fill_hit) begin
                entries[fill_idx].state <= FILLED;
                entries[fill_idx].inst  <= fill_data;
            end
            if (alloc) begin
                entries[tail] <= '{state: PENDING, pc: alloc_pc, inst: 32'h0};
                tail          <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + PTR_W'(1);
            end
            if (deq) begin
                entries[head].state <= EMPTY;
                head                <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + PTR_W'(1);
            end
            // NOTE: sequential state uses non-blocking assignments so every
            // right-hand side sees the pre-edge values.
            count <= count + CNT_W'(alloc) - CNT_W'(deq);
        end
    end

    assign head_filled = (entries[head].state == FILLED);
    assign head_pc     = entries[head].pc;
    assign head_inst   = entries[head].inst;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, in-order word requests to instruction
// memory, response drop counter for flushed requests, and a fetch_queue that
// presents words with their PCs to ID over valid/ready.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   imem_req/addr/gnt                   : request channel to instruction memory
//   imem_rvalid/rdata                   : in-order response channel
//   redirect, redirect_pc               : flush and restart fetch at a new target
//   inst_valid/ready, inst, inst_pc     : handshake toward ID
//   misalign                            : misaligned redirect target fault
// Configuration: define FETCH_MISALIGN_CHK_EN to flag misaligned redirect targets
// (sticky until an aligned redirect); otherwise the low two target bits are
// dropped and misalign stays 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc;
    logic             active;      // low only in the cycle reset releases
    logic [CNT_W-1:0] drop_cnt;    // responses still owed for flushed requests
    logic [CNT_W-1:0] drop_nxt;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] q_pending;
    logic [CNT_W:0]   in_flight;
    logic             head_filled;
    logic             alloc;
    logic             fill;
    logic             deq;
    logic [31:0]      target;
    logic             target_bad;
    logic             misalign_q;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target     = redirect_pc;
    assign target_bad = |redirect_pc[1:0];
`else
    assign target     = redirect_pc & 32'hFFFF_FFFC;
    assign target_bad = 1'b0;
`endif

    // Queue slots plus responses owed to flushed requests bound the requests
    // that may be outstanding at once.
    assign in_flight = {1'b0, q_count} + {1'b0, drop_cnt};
    assign imem_req  = active && (in_flight < (CNT_W + 1)'(DEPTH)) && !redirect && !misalign_q;
    assign alloc     = imem_req && imem_gnt;
    assign fill      = imem_rvalid && (drop_cnt == '0) && !redirect;
    assign inst_valid = head_filled && !redirect;
    assign deq       = inst_valid && inst_ready;

    // On redirect every PENDING entry becomes a response to drop, except that a
    // response arriving in the redirect cycle itself is consumed right away.
    always_comb begin
        drop_nxt = drop_cnt;
        if (redirect) begin
            drop_nxt = drop_cnt + q_pending;
            if (imem_rvalid && drop_nxt != '0) drop_nxt = drop_nxt - CNT_W'(1);
        end else if (imem_rvalid && drop_cnt != '0) begin
            drop_nxt = drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            active     <= 1'b0;
            drop_cnt   <= '0;
            misalign_q <= 1'b0;
        end else begin
            active   <= 1'b1;
            drop_cnt <= drop_nxt;
            if (redirect) begin
                pc         <= target;
                misalign_q <= target_bad;
            end else if (alloc) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (alloc),
        .alloc_pc    (pc),
        .fill        (fill),
        .fill_data   (imem_rdata),
        .deq         (deq),
        .flush       (redirect),
        .count       (q_count),
        .pending     (q_pending),
        .head_filled (head_filled),
        .head_pc     (inst_pc),
        .head_inst   (inst)
    );

    assign imem_addr = pc;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2). A behavioural instruction memory
// returns granted words in order, one cycle after grant unless stalled.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;

    int          checks = 0;
    int          failures = 0;
    int          grants = 0;
    int          g0;
    logic        mem_stall = 1'b0;
    logic [31:0] mem_q [$];

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .misalign    (misalign)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1359_0913;
            32'h0000_0004: return 32'h0084_8933;
            default:       return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    // Instruction memory: accept on the falling edge where req&&gnt holds,
    // answer 2ns after the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && imem_req && imem_gnt) begin
                mem_q.push_back(imem_addr);
                grants++;
            end
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mem_q.delete();
                imem_rvalid = 1'b0;
            end else if (!mem_stall && mem_q.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Ends 1ns after the first rising edge with rst_n high ("cycle 0").
    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        imem_gnt    = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_stall   = 1'b0;
        repeat (2) @(posedge clk);
        sample();
        check({tag, "_rst_req"},   imem_req,   32'd0);
        check({tag, "_rst_valid"}, inst_valid, 32'd0);
        check({tag, "_rst_mis"},   misalign,   32'd0);
        check({tag, "_rst_addr"},  imem_addr,  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Basic fetch: grant in C1, response in C2, first instruction in C3.
        do_reset("t1");
        next_cycle(); sample();
        check("t1_req_c1",   imem_req,   32'd1);
        check("t1_addr_c1",  imem_addr,  32'h0);
        check("t1_valid_c1", inst_valid, 32'd0);
        next_cycle(); sample();
        check("t1_valid_c2", inst_valid, 32'd0);
        check("t1_addr_c2",  imem_addr,  32'h4);
        next_cycle(); sample();
        check("t1_valid_c3", inst_valid, 32'd1);
        check("t1_pc_c3",    inst_pc,    32'h0);
        check("t1_inst_c3",  inst,       32'h1359_0913);
        next_cycle(); sample();
        check("t1_valid_c4", inst_valid, 32'd1);
        check("t1_pc_c4",    inst_pc,    32'h4);
        check("t1_inst_c4",  inst,       32'h0084_8933);

        // ID stalled: two grants fill the queue, then requests stop at 0x8.
        do_reset("t2");
        inst_ready = 1'b0;
        g0 = grants;
        next_cycle(); sample();
        check("t2_req_c1",   imem_req,   32'd1);
        next_cycle(); sample();
        check("t2_addr_c2",  imem_addr,  32'h4);
        next_cycle(); sample();
        check("t2_req_c3",   imem_req,   32'd0);
        check("t2_addr_c3",  imem_addr,  32'h8);
        next_cycle(); sample();
        check("t2_req_c4",   imem_req,   32'd0);
        check("t2_valid_c4", inst_valid, 32'd1);
        check("t2_pc_c4",    inst_pc,    32'h0);
        next_cycle(); sample();
        check("t2_addr_c5",  imem_addr,  32'h8);
        check("t2_grants",   grants - g0, 32'd2);
        next_cycle();
        inst_ready = 1'b1;
        sample();
        check("t2_pc_c6",    inst_pc,    32'h0);
        next_cycle(); sample();
        check("t2_pc_c7",    inst_pc,    32'h4);
        check("t2_req_c7",   imem_req,   32'd1);
        check("t2_addr_c7",  imem_addr,  32'h8);
        next_cycle(); sample();
        check("t2_valid_c8", inst_valid, 32'd0);
        next_cycle(); sample();
        check("t2_valid_c9", inst_valid, 32'd1);
        check("t2_pc_c9",    inst_pc,    32'h8);
        check("t2_inst_c9",  inst,       32'hDEAD_0008);
        // Asynchronous reset mid-operation clears outputs without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("t2_arst_valid", inst_valid, 32'd0);
        check("t2_arst_req",   imem_req,   32'd0);
        check("t2_arst_addr",  imem_addr,  32'h0);

        // Redirect with two requests outstanding: both responses are dropped.
        do_reset("t3");
        mem_stall = 1'b1;
        next_cycle(); sample();
        check("t3_addr_c1",  imem_addr,  32'h0);
        next_cycle(); sample();
        check("t3_addr_c2",  imem_addr,  32'h4);
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h100;
        sample();
        check("t3_req_c3",   imem_req,   32'd0);
        check("t3_valid_c3", inst_valid, 32'd0);
        next_cycle();
        redirect = 1'b0; mem_stall = 1'b0;
        sample();
        check("t3_req_c4",   imem_req,   32'd0);
        check("t3_valid_c4", inst_valid, 32'd0);
        next_cycle(); sample();
        check("t3_req_c5",   imem_req,   32'd1);
        check("t3_addr_c5",  imem_addr,  32'h100);
        check("t3_valid_c5", inst_valid, 32'd0);
        next_cycle(); sample();
        check("t3_valid_c6", inst_valid, 32'd0);
        next_cycle(); sample();
        check("t3_valid_c7", inst_valid, 32'd1);
        check("t3_pc_c7",    inst_pc,    32'h100);
        check("t3_inst_c7",  inst,       32'hDEAD_0100);

        // Redirect in the same cycle as a response and a would-be dequeue.
        do_reset("t4");
        next_cycle(); next_cycle();
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h40;
        sample();
        check("t4_valid_c3", inst_valid, 32'd0);
        check("t4_req_c3",   imem_req,   32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("t4_req_c4",   imem_req,   32'd1);
        check("t4_addr_c4",  imem_addr,  32'h40);
        check("t4_valid_c4", inst_valid, 32'd0);
        next_cycle(); sample();
        check("t4_addr_c5",  imem_addr,  32'h44);
        check("t4_valid_c5", inst_valid, 32'd0);
        next_cycle(); sample();
        check("t4_valid_c6", inst_valid, 32'd1);
        check("t4_pc_c6",    inst_pc,    32'h40);
        check("t4_inst_c6",  inst,       32'hDEAD_0040);
        next_cycle(); sample();
        check("t4_pc_c7",    inst_pc,    32'h44);

        // Grant withheld for three cycles: address holds, PC moves only on grant.
        do_reset("t5");
        imem_gnt = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); sample();
            check($sformatf("t5_req_c%0d", c),  imem_req,  32'd1);
            check($sformatf("t5_addr_c%0d", c), imem_addr, 32'h0);
        end
        next_cycle();
        imem_gnt = 1'b1;
        sample();
        check("t5_addr_c4",  imem_addr,  32'h0);
        next_cycle(); sample();
        check("t5_addr_c5",  imem_addr,  32'h4);
        next_cycle(); sample();
        check("t5_pc_c6",    inst_pc,    32'h0);
        check("t5_inst_c6",  inst,       32'h1359_0913);

        // Misaligned redirect target, then an aligned one.
        do_reset("t6");
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h102;
        sample();
        check("t6_req_c1",   imem_req,   32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
`ifdef FETCH_MISALIGN_CHK_EN
        check("t6_mis_c2",   misalign,   32'd1);
        check("t6_req_c2",   imem_req,   32'd0);
        check("t6_addr_c2",  imem_addr,  32'h102);
`else
        check("t6_mis_c2",   misalign,   32'd0);
        check("t6_req_c2",   imem_req,   32'd1);
        check("t6_addr_c2",  imem_addr,  32'h100);
`endif
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h200;
        sample();
        check("t6_req_c3",   imem_req,   32'd0);
        next_cycle();
        redirect = 1'b0;
        sample();
        check("t6_mis_c4",   misalign,   32'd0);
        check("t6_req_c4",   imem_req,   32'd1);
        check("t6_addr_c4",  imem_addr,  32'h200);
        next_cycle(); sample();
        check("t6_valid_c5", inst_valid, 32'd0);
        next_cycle(); sample();
        check("t6_valid_c6", inst_valid, 32'd1);
        check("t6_pc_c6",    inst_pc,    32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
